keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low matrix keypad and reports debounced key presses to the rest of the design. It is the input-side counterpart of the multiplexed display driver: it walks a one-hot active-low select across the keypad columns, samples the row lines, debounces, and emits a 4-bit key code with a one-cycle valid strobe. It sits between the board keypad pins and the CPU's memory-mapped I/O.

## Interface
- `SCAN_DIV`, 65536: clocks per column dwell. Must be ≥ 4.
- `DEBOUNCE_SAMPLES`, 4: consecutive agreeing samples required to accept a press or a release. Must be ≥ 1.
- `REPEAT_DELAY`, 64: samples from acceptance to the first auto-repeat. Used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_RATE`, 16: samples between subsequent auto-repeats. Used only with `KEYPAD_REPEAT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `row_in` in 4: keypad rows, externally pulled up; low means pressed. Asynchronous to `clk`.
- `col_out` out 4: column select, active-low one-hot.
- `key_code` out 4: `{row_idx[1:0], col_idx[1:0]}` of the last accepted key.
- `key_valid` out 1: one-cycle strobe when `key_code` is updated or repeated.
- `key_held` out 1: high while an accepted key is still pressed.

## Operation
- Synchronization: `row_in` always passes through a two-flop synchronizer (reset value 4'b1111). All decisions use the synchronized value.
- Divider:
  - Counts 0..`SCAN_DIV`-1 and wraps.
  - A sample is taken on the cycle where the count equals `SCAN_DIV`-1.
  - Counter width is `$clog2(SCAN_DIV)`.
- Column index: `col_idx`, 2 bits, wraps 3→0. `col_out = ~(4'b0001 << col_idx)`.
- Row priority: if several rows are low, the lowest index wins.
- FSM states: `SCAN`, `DEBOUNCE`, `HELD`, `RELEASE`.
  - `SCAN`:
    - Sample with no row low → advance `col_idx`.
    - Sample with a row low → latch the candidate row and go to `DEBOUNCE` with `deb_cnt`=1. The column stays frozen.
  - `DEBOUNCE`:
    - Sample where the candidate row is still low → `deb_cnt`++.
    - When `deb_cnt` reaches `DEBOUNCE_SAMPLES` → load `key_code`, pulse `key_valid`, go to `HELD`.
    - Candidate row high, or a different winning row → return to `SCAN` and advance the column. No strobe.
    - With `DEBOUNCE_SAMPLES`=1, the press is accepted on the first sample, so the transition goes from `SCAN` directly to `HELD`.
  - `HELD`:
    - `key_held`=1. The column stays frozen.
    - Sample with the row high → go to `RELEASE` with `deb_cnt`=1.
  - `RELEASE`:
    - Sample with the row low → back to `HELD`.
    - `DEBOUNCE_SAMPLES` consecutive high samples → go to `SCAN`, `key_held`=0, advance the column.
- Other keys pressed while in `HELD` or `RELEASE` are ignored (no rollover).
- A key is reported once per press, except under auto-repeat.

## Timing
- Reset values:
  - `col_out`=4'b1110
  - `key_code`=0
  - `key_valid`=0
  - `key_held`=0
  - state `SCAN`
  - all counters 0
- Reset is asynchronous: it takes effect immediately, including mid-debounce or mid-hold.
- Column dwell is exactly `SCAN_DIV` clocks.
- Latencies:
  - `key_valid` and the new `key_code` appear on the clock edge that registers the `DEBOUNCE_SAMPLES`-th confirming sample.
  - `key_held` rises on the same edge.
  - `key_held` falls on the edge that registers the final confirming release sample. The new column appears on that same edge.
- `key_valid` is never high for more than one consecutive cycle.
- Sync latency is 2 clocks. `SCAN_DIV` ≥ 4 guarantees rows have settled before sampling after a column change.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In `HELD`, a repeat counter counts samples from acceptance.
  - At `REPEAT_DELAY` samples, `key_valid` pulses with an unchanged `key_code`.
  - After that, it pulses every `REPEAT_RATE` samples.
  - The counter clears on leaving `HELD`. A return from `RELEASE` to `HELD` restarts `REPEAT_DELAY`.
- Not defined: no repeat logic is present, and `key_valid` pulses once per accepted press.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE_SAMPLES`=3 unless noted.
- Reset: assert `reset_n`=0 mid-run → `col_out`=1110, `key_code`=0, `key_valid`=0, `key_held`=0 immediately.
- Idle scan: `row_in`=1111 → `col_out` steps 1110→1101→1011→0111→1110, 4 clocks per step.
- Clean press:
  - Stimulus: row 2 low while `col_out`=1101.
  - Required response: after 3 samples, a single `key_valid` pulse, `key_code`=4'b1001, `key_held`=1, `col_out` frozen at 1101.
- Bounce: row 2 low for 2 samples, then high → no `key_valid`, scan resumes at `col_out`=1011.
- Release: after the clean press, rows high → `key_held` falls after the 3rd high sample, `col_out`=1011. A single low glitch in `RELEASE` returns to `HELD` with no new strobe.
- Repeat (`KEYPAD_REPEAT_EN`, `REPEAT_DELAY`=8, `REPEAT_RATE`=2): hold the key → `key_valid` pulses at acceptance, +8 samples, then every 2 samples.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce, one-cycle key strobe and held flag.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV         = 65536,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int REPEAT_DELAY     = 64,
    parameter int REPEAT_RATE      = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    function automatic logic [1:0] lowest_row(input logic [3:0] low);
        logic [1:0] idx;
        if (low[0]) begin
            idx = 2'd0;
        end else if (low[1]) begin
            idx = 2'd1;
        end else if (low[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    logic [3:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] div_q, div_d;
    state_e           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       cand_q, cand_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic [3:0]       col_out_q, col_out_d;

    logic             sample_s;
    logic [3:0]       row_low_s;
    logic             any_low_s;
    logic [1:0]       win_s;
    logic             cand_low_s;
    logic [DEB_W-1:0] deb_inc_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_armed_q, rpt_armed_d;
    logic [RPT_W-1:0] rpt_inc_s;
    logic [RPT_W-1:0] rpt_target_s;
`else
    logic [63:0] unused_repeat_cfg_s;
    assign unused_repeat_cfg_s = {32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
        end
    end

    // Divider, scan FSM and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            cand_q    <= 2'd0;
            deb_q     <= '0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            col_out_q <= 4'b1110;
        end else begin
            div_q     <= div_d;
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            cand_q    <= cand_d;
            deb_q     <= deb_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            col_out_q <= col_out_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat sample counter and first-repeat flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_q       <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`endif

    // Next-state and output decode; only sample cycles move the FSM
    always_comb begin
        div_d     = div_q;
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cand_d    = cand_q;
        deb_d     = deb_q;
        code_d    = code_q;
        valid_d   = 1'b0;

        row_low_s  = ~sync2_q;
        any_low_s  = |row_low_s;
        win_s      = lowest_row(row_low_s);
        cand_low_s = row_low_s[cand_q];
        deb_inc_s  = deb_q + 1'b1;
        sample_s   = (div_q == DIV_LAST);

        if (sample_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

`ifdef KEYPAD_REPEAT_EN
        rpt_d        = rpt_q;
        rpt_armed_d  = rpt_armed_q;
        rpt_inc_s    = rpt_q + 1'b1;
        rpt_target_s = rpt_armed_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY);
`endif

        if (sample_s) begin
            case (state_q)
                ST_SCAN: begin
                    if (any_low_s) begin
                        cand_d = win_s;
                        if (DEBOUNCE_SAMPLES == 1) begin
                            code_d  = {win_s, col_idx_q};
                            valid_d = 1'b1;
                            state_d = ST_HELD;
                            deb_d   = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            deb_d   = DEB_W'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    // A different winning row means the press was not stable
                    if (any_low_s && (win_s == cand_q)) begin
                        if (deb_inc_s == DEB_LAST) begin
                            code_d  = {cand_q, col_idx_q};
                            valid_d = 1'b1;
                            state_d = ST_HELD;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_inc_s;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        deb_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    if (!cand_low_s) begin
                        if (DEBOUNCE_SAMPLES == 1) begin
                            state_d   = ST_SCAN;
                            deb_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                        end else begin
                            state_d = ST_RELEASE;
                            deb_d   = DEB_W'(1);
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_inc_s == rpt_target_s) begin
                            valid_d     = 1'b1;
                            rpt_d       = '0;
                            rpt_armed_d = 1'b1;
                        end else begin
                            rpt_d = rpt_inc_s;
                        end
`else
                        state_d = ST_HELD;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (cand_low_s) begin
                        state_d = ST_HELD;
                        deb_d   = '0;
                    end else if (deb_inc_s == DEB_LAST) begin
                        state_d   = ST_SCAN;
                        deb_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        deb_d = deb_inc_s;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    deb_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

`ifdef KEYPAD_REPEAT_EN
        // Any entry into HELD (acceptance or bounce back from RELEASE) restarts the delay
        if ((state_d != ST_HELD) || (state_q != ST_HELD)) begin
            rpt_d       = '0;
            rpt_armed_d = 1'b0;
        end else begin
            rpt_armed_d = rpt_armed_d;
        end
`endif

        held_d    = (state_d == ST_HELD) || (state_d == ST_RELEASE);
        col_out_d = ~(4'b0001 << col_idx_d);
    end

    assign col_out   = col_out_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner against a sample-level reference model.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int RD = 8;
    localparam int RR = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row_in = 4'b1111;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE_SAMPLES(DS),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .row_in(row_in),
        .col_out(col_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    int n_checks = 0;
    int n_pass = 0;
    int pulses = 0;
    logic prev_valid = 1'b0;

    // Reference model state: modes 0 idle, 1 debouncing, 2 held, 3 releasing
    logic [3:0] m_s1, m_s2, m_code;
    int m_div, m_col, m_mode, m_cand, m_cnt, m_since;
    logic m_valid, m_held;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_s1 = 4'b1111; m_s2 = 4'b1111; m_code = 4'd0;
        m_div = 0; m_col = 0; m_mode = 0; m_cand = 0; m_cnt = 0; m_since = 0;
        m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_accept();
        m_code = 4'(m_cand * 4 + m_col);
        m_valid = 1'b1; m_held = 1'b1; m_mode = 2; m_since = 0;
    endtask

    task automatic model_leave();
        m_mode = 0; m_held = 1'b0; m_col = (m_col + 1) % 4;
    endtask

    task automatic model_sample(input logic [3:0] used);
        int w;
        w = -1;
        for (int i = 3; i >= 0; i--) if (!used[i]) w = i;
        case (m_mode)
            0: begin
                if (w < 0) m_col = (m_col + 1) % 4;
                else begin
                    m_cand = w; m_cnt = 1;
                    if (m_cnt >= DS) model_accept(); else m_mode = 1;
                end
            end
            1: begin
                if (w == m_cand) begin
                    m_cnt++;
                    if (m_cnt >= DS) model_accept();
                end else begin
                    m_mode = 0; m_col = (m_col + 1) % 4;
                end
            end
            2: begin
                if (used[m_cand]) begin
                    m_cnt = 1;
                    if (m_cnt >= DS) model_leave(); else m_mode = 3;
                end else begin
                    m_since++;
`ifdef KEYPAD_REPEAT_EN
                    if (m_since == RD || (m_since > RD && (m_since - RD) % RR == 0)) m_valid = 1'b1;
`endif
                end
            end
            3: begin
                if (!used[m_cand]) begin
                    m_mode = 2; m_since = 0;
                end else begin
                    m_cnt++;
                    if (m_cnt >= DS) model_leave();
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic model_edge(input logic [3:0] rin);
        logic [3:0] used;
        logic smp;
        used = m_s2; m_s2 = m_s1; m_s1 = rin;
        smp = (m_div == SD - 1);
        m_div = (m_div + 1) % SD;
        m_valid = 1'b0;
        if (smp) model_sample(used);
    endtask

    task automatic tick();
        logic [3:0] one;
        one = 4'b0001;
        @(posedge clk);
        model_edge(row_in);
        #1;
        check_val("col_out", {4'd0, col_out}, {4'd0, ~(one << m_col)});
        check_val("key_code", {4'd0, key_code}, {4'd0, m_code});
        check_val("key_valid", {7'd0, key_valid}, {7'd0, m_valid});
        check_val("key_held", {7'd0, key_held}, {7'd0, m_held});
        if (key_valid) begin
            check_val("valid_run", {7'd0, prev_valid}, 8'd0);
            pulses++;
        end
        prev_valid = key_valid;
    endtask

    task automatic hold(input logic [3:0] r, input int n);
        row_in = r;
        repeat (n) tick();
    endtask

    task automatic wait_col(input logic [3:0] c);
        int guard;
        guard = 0;
        while (col_out != c && guard < 40) begin
            tick();
            guard++;
        end
        check_val("wait_col", {4'd0, col_out}, {4'd0, c});
    endtask

    task automatic check_reset_vals();
        check_val("rst_col", {4'd0, col_out}, 8'h0E);
        check_val("rst_code", {4'd0, key_code}, 8'h00);
        check_val("rst_valid", {7'd0, key_valid}, 8'h00);
        check_val("rst_held", {7'd0, key_held}, 8'h00);
    endtask

    initial begin
        logic [3:0] idle_tbl [5];
        logic [3:0] pat;
        int exp_pulses;
        int guard;
        idle_tbl[0] = 4'b1110; idle_tbl[1] = 4'b1101; idle_tbl[2] = 4'b1011;
        idle_tbl[3] = 4'b0111; idle_tbl[4] = 4'b1110;

        model_reset();
        #12;
        check_reset_vals();
        reset_n = 1'b1;

        // Idle scan: one column step every SD clocks
        check_val("idle0", {4'd0, col_out}, {4'd0, idle_tbl[0]});
        for (int k = 1; k < 5; k++) begin
            hold(4'b1111, SD);
            check_val("idle_step", {4'd0, col_out}, {4'd0, idle_tbl[k]});
        end

        // Clean press of row 2 on column 1
        wait_col(4'b1101);
        pulses = 0;
        hold(4'b1011, 40);
        check_val("press_pulses", 8'(pulses), 8'd1);
        check_val("press_code", {4'd0, key_code}, 8'h09);
        check_val("press_held", {7'd0, key_held}, 8'd1);
        check_val("press_col", {4'd0, col_out}, 8'h0D);

        // One high sample while held must bounce back without a strobe
        pulses = 0;
        hold(4'b1111, SD);
        hold(4'b1011, 20);
        check_val("glitch_pulses", 8'(pulses), 8'd0);
        check_val("glitch_held", {7'd0, key_held}, 8'd1);

        // Release: held drops together with the column advance
        row_in = 4'b1111;
        guard = 0;
        while (key_held && guard < 40) begin
            tick();
            guard++;
        end
        check_val("release_held", {7'd0, key_held}, 8'd0);
        check_val("release_col", {4'd0, col_out}, 8'h0B);

        // Bounce: two low samples then high aborts and advances the column
        wait_col(4'b1101);
        pulses = 0;
        hold(4'b1011, 2 * SD);
        hold(4'b1111, SD);
        check_val("bounce_pulses", 8'(pulses), 8'd0);
        check_val("bounce_col", {4'd0, col_out}, 8'h0B);

        // Long hold: one strobe, or acceptance plus repeats when enabled
        wait_col(4'b1101);
        pulses = 0;
        hold(4'b1011, 68);
`ifdef KEYPAD_REPEAT_EN
        exp_pulses = 5;
`else
        exp_pulses = 1;
`endif
        check_val("long_pulses", 8'(pulses), 8'(exp_pulses));
        hold(4'b1111, 20);

        // Random row activity with occasional asynchronous reset
        for (int it = 0; it < 250; it++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 55) pat = 4'b1111;
            else if (sel < 90) begin
                pat = 4'b1111;
                pat[$urandom_range(0, 3)] = 1'b0;
            end else pat = 4'($urandom);
            hold(pat, int'($urandom_range(1, 30)));
            if ($urandom_range(0, 39) == 0) begin
                reset_n = 1'b0;
                #2;
                model_reset();
                check_reset_vals();
                #2;
                reset_n = 1'b1;
                prev_valid = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
